// File: rtl/rgb2ycbcr_stream.sv
// Streaming RGB -> YCbCr converter: three-stage fixed-point pipeline feeding a
// first-word-fall-through output FIFO, with input flow control by credit.
module rgb2ycbcr_stream #(
  parameter int PIX_W      = 8,
  parameter int COEF_FRAC  = 14,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3*PIX_W-1:0] in_data,
  input  logic               in_last,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3*PIX_W-1:0] out_data,
  output logic               out_last,
  output logic [31:0]        pix_count
);

  localparam int CW = COEF_FRAC + 2;
  localparam int PW = PIX_W + COEF_FRAC + 3;
  localparam int SW = PIX_W + COEF_FRAC + 4;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = 3 * PIX_W;

  localparam longint OFF_C  = longint'(1) << (PIX_W - 1 + COEF_FRAC);
  localparam longint OFF_YL = longint'(16) << (PIX_W - 8 + COEF_FRAC);
  localparam longint RND    = longint'(1) << (COEF_FRAC - 1);
  localparam longint MAXPIX = (longint'(1) << PIX_W) - 1;

  // idx = channel*3 + component (Y/Cb/Cr x R/G/B); coefficients kept as
  // millionths so the limited-range scaling rounds exactly once.
  function automatic longint coef_q(input int idx, input bit lim);
    longint num;
    longint den;
    longint mag;
    case (idx)
      0:       num = 299000;
      1:       num = 587000;
      2:       num = 114000;
      3:       num = -168736;
      4:       num = -331264;
      5:       num = 500000;
      6:       num = 500000;
      7:       num = -418688;
      8:       num = -81312;
      default: num = 0;
    endcase
    den = 1000000;
    if (lim) begin
      num = num * ((idx < 3) ? 219 : 224);
      den = den * 255;
    end
    num = num * (longint'(1) << COEF_FRAC);
    mag = (num < 0) ? -num : num;
    mag = (2 * mag + den) / (2 * den);
    return (num < 0) ? -mag : mag;
  endfunction

  logic                 run_reg;
  logic                 accept;
  logic                 s1_valid_reg, s1_last_reg, s1_mode_reg;
  logic                 s2_valid_reg, s2_last_reg;
  logic                 s3_valid_reg, s3_last_reg;
  logic [DW-1:0]        s3_data;
  logic signed [PW-1:0] r_s, g_s, b_s;

  logic [DW:0]          fifo_mem [FIFO_DEPTH];
  logic [DW:0]          head;
  logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]          count_reg, count_next;
  logic [AW+1:0]        inflight;
  logic                 wr_en, rd_en;
  logic [31:0]          pix_count_reg;

  assign r_s = PW'(in_data[0*PIX_W +: PIX_W]);
  assign g_s = PW'(in_data[1*PIX_W +: PIX_W]);
  assign b_s = PW'(in_data[2*PIX_W +: PIX_W]);

  // Credit: buffered plus in-flight pixels can never exceed the FIFO depth.
  assign inflight = (AW+2)'(count_reg) + (AW+2)'(s1_valid_reg)
                  + (AW+2)'(s2_valid_reg) + (AW+2)'(s3_valid_reg);
  assign in_ready = run_reg && (inflight < (AW+2)'(FIFO_DEPTH));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_reg      <= 1'b0;
      s1_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      s1_mode_reg  <= 1'b0;
      s2_valid_reg <= 1'b0;
      s2_last_reg  <= 1'b0;
      s3_valid_reg <= 1'b0;
      s3_last_reg  <= 1'b0;
    end else begin
      run_reg      <= 1'b1;
      s1_valid_reg <= accept;
      s1_last_reg  <= in_last;
      s1_mode_reg  <= mode;
      s2_valid_reg <= s1_valid_reg;
      s2_last_reg  <= s1_last_reg;
      s3_valid_reg <= s2_valid_reg;
      s3_last_reg  <= s2_last_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      localparam logic signed [CW-1:0] CF_R = CW'(coef_q(3*gi + 0, 1'b0));
      localparam logic signed [CW-1:0] CF_G = CW'(coef_q(3*gi + 1, 1'b0));
      localparam logic signed [CW-1:0] CF_B = CW'(coef_q(3*gi + 2, 1'b0));
      localparam logic signed [CW-1:0] CL_R = CW'(coef_q(3*gi + 0, 1'b1));
      localparam logic signed [CW-1:0] CL_G = CW'(coef_q(3*gi + 1, 1'b1));
      localparam logic signed [CW-1:0] CL_B = CW'(coef_q(3*gi + 2, 1'b1));
      localparam logic signed [SW-1:0] OFF_F = SW'((gi == 0) ? longint'(0) : OFF_C);
      localparam logic signed [SW-1:0] OFF_L = SW'((gi == 0) ? OFF_YL : OFF_C);
      localparam logic signed [SW-1:0] RND_V = SW'(RND);
      localparam logic signed [SW-1:0] MAX_V = SW'(MAXPIX);

      logic signed [PW-1:0] coef_r, coef_g, coef_b;
      logic signed [PW-1:0] prod_r_reg, prod_g_reg, prod_b_reg;
      logic signed [SW-1:0] sum_next, sum_reg, shifted;
      logic [PIX_W-1:0]     sat_next, res_reg;

      assign coef_r = mode ? PW'(CL_R) : PW'(CF_R);
      assign coef_g = mode ? PW'(CL_G) : PW'(CF_G);
      assign coef_b = mode ? PW'(CL_B) : PW'(CF_B);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prod_r_reg <= '0;
          prod_g_reg <= '0;
          prod_b_reg <= '0;
        end else begin
          prod_r_reg <= r_s * coef_r;
          prod_g_reg <= g_s * coef_g;
          prod_b_reg <= b_s * coef_b;
        end
      end

      // Offset follows the mode captured with this pixel, not the live input.
      assign sum_next = SW'(prod_r_reg) + SW'(prod_g_reg) + SW'(prod_b_reg)
                      + (s1_mode_reg ? OFF_L : OFF_F) + RND_V;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum_reg <= '0;
        else        sum_reg <= sum_next;
      end

      always_comb begin
        shifted = sum_reg >>> COEF_FRAC;
        if (shifted[SW-1])        sat_next = '0;
        else if (shifted > MAX_V) sat_next = '1;
        else                      sat_next = shifted[PIX_W-1:0];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) res_reg <= '0;
        else        res_reg <= sat_next;
      end

      assign s3_data[gi*PIX_W +: PIX_W] = res_reg;
    end
  endgenerate

  assign wr_en      = s3_valid_reg;
  assign rd_en      = out_valid && out_ready;
  assign count_next = count_reg + (AW+1)'(wr_en) - (AW+1)'(rd_en);

  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem[wr_ptr_reg] <= {s3_last_reg, s3_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      pix_count_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_en) begin
        rd_ptr_reg    <= rd_ptr_reg + AW'(1);
        pix_count_reg <= pix_count_reg + 32'd1;
      end
      count_reg <= count_next;
    end
  end

  // Head is gated so stale RAM contents never show while the FIFO is empty.
  assign head      = fifo_mem[rd_ptr_reg];
  assign out_valid = (count_reg != '0);
  assign out_data  = out_valid ? head[DW-1:0] : '0;
  assign out_last  = out_valid && head[DW];
  assign pix_count = pix_count_reg;

endmodule

// File: doc/rgb2ycbcr_stream.md
RGB2YCBCR_STREAM -- requirements
Module: rgb2ycbcr_stream

Interface
REQ-001 SHALL have parameter PIX_W, default 8, component width in bits (8..12).
REQ-002 SHALL have parameter COEF_FRAC, default 14, fractional bits of fixed-point coefficients (10..16).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output FIFO entries (power of 2, >=4).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  input pixel valid.
REQ-007 SHALL have port in_ready  output  1  block accepts a pixel this cycle.
REQ-008 SHALL have port in_data  input  3*PIX_W  pixel {B,G,R}, R in LSBs.
REQ-009 SHALL have port in_last  input  1  last pixel of a block/frame, carried through.
REQ-010 SHALL have port mode  input  1  0 = full range (JFIF), 1 = limited range (BT.601 studio); sampled per pixel.
REQ-011 SHALL have port out_valid  output  1  output pixel valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts.
REQ-013 SHALL have port out_data  output  3*PIX_W  {Cr,Cb,Y}, Y in LSBs.
REQ-014 SHALL have port out_last  output  1  in_last of the pixel on out_data.
REQ-015 SHALL have port pix_count  output  32  count of output handshakes since reset, wraps at 2^32.

Function
REQ-016 Input transfer SHALL occur on a rising edge where in_valid && in_ready; output transfer where out_valid && out_ready.
REQ-017 Pipeline SHALL be 3 stages: S1 nine products, S2 sum + offset + rounding, S3 saturation and FIFO write; stages never stall.
REQ-018 in_ready SHALL be 1 iff (FIFO occupancy + pixels in S1..S3) < FIFO_DEPTH (credit scheme, no FIFO overflow possible).
REQ-019 A pixel accepted at edge N SHALL be written to the FIFO at edge N+3; with FIFO empty, out_valid SHALL be 1 in the cycle after edge N+3.
REQ-020 FIFO SHALL be first-word-fall-through; out_data/out_last SHALL hold stable while out_valid && !out_ready.
REQ-021 Simultaneous FIFO write and read SHALL leave occupancy unchanged; a write to a full FIFO SHALL not occur (guaranteed by REQ-018).
REQ-022 Coefficients SHALL be integers round(c * 2^COEF_FRAC), signed. Full range: Y = .299R + .587G + .114B; Cb = -.168736R - .331264G + .5B + 2^(PIX_W-1); Cr = .5R - .418688G - .081312B + 2^(PIX_W-1).
REQ-023 Limited mode SHALL scale the Y coefficients by 219/255 and the Cb/Cr coefficients by 224/255, then add Y offset 16*2^(PIX_W-8) and C offset 2^(PIX_W-1).
REQ-024 Intermediate sums SHALL be signed, at least PIX_W+COEF_FRAC+3 bits; no overflow.
REQ-025 Result SHALL be (sum + 2^(COEF_FRAC-1)) >>> COEF_FRAC, then saturated to [0, 2^PIX_W-1].
REQ-026 mode and in_last SHALL travel with their pixel; changing mode between pixels SHALL not affect pixels already in flight.
REQ-027 pix_count SHALL increment by 1 on each output transfer.

Reset
REQ-028 While rst_n = 0: in_ready = 0, out_valid = 0, out_last = 0, out_data = 0, pix_count = 0, FIFO empty, all stage valids cleared.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight and buffered pixels; no stale output after deassertion.
REQ-030 in_ready SHALL rise in the first cycle after rst_n deasserts.

Verification (PIX_W=8, COEF_FRAC=14)
REQ-031 Full mode, back-to-back, out_ready=1: red (255,0,0) -> Y=76 Cb=85 Cr=255 (saturated); green (0,255,0) -> 150,44,21; white -> 255,128,128; black -> 0,128,128; first output 3 edges after acceptance.
REQ-032 Limited mode: black -> Y=16 Cb=128 Cr=128; white -> Y=235 Cb=128 Cr=128.
REQ-033 out_ready=0 with in_valid=1 continuously -> exactly 4 pixels accepted, in_ready=0 thereafter; after out_ready=1, the 4 pixels emerge in order with data held stable while stalled.
REQ-034 Random in_valid/out_ready over 1000 pixels with in_last every 64th pixel and random mode -> outputs match reference model in order, out_last on every 64th output, pix_count=1000.
REQ-035 rst_n pulsed low with 3 pixels in flight and 2 buffered -> out_valid=0 immediately, pix_count=0, no stale output after release.
